ti_sbox_host: RTL and testbench

//  Host-side initiator for the serial threshold-implementation (TI) S-box port.
//  - Splits an unmasked byte into three Boolean shares and adds two mask bytes.
//  - Streams the five bytes into the S-box port, then captures its three output shares.
//  - XOR-recombines the output shares into the unmasked result.
//  - Sits between the test/control logic and the S-box wrapper's ui_in/ena/uio_out[0]/uo_out pins.

---
 rtl/ti_sbox_pkg.sv | 47 ++++
 rtl/ti_sbox_host_if.sv | 24 ++
 rtl/ti_host_lfsr.sv | 29 ++
 rtl/ti_sbox_host.sv | 176 +++++++++++++++++
 tb/tb_ti_sbox_host.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ti_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ti_sbox_pkg
// Purpose  : Shared types and constants for the TI S-box host slice.
// Revision : 1.0 - initial release
// ============================================================================
package ti_sbox_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_LOAD = 3'd2,
        ST_WAIT = 3'd3,
        ST_SKIP = 3'd4,
        ST_CAP  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam int NUM_IN_BYTES = 5;
    localparam int NUM_SHARES   = 3;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;

    // Golden AES S-box, referenced by benches only
    localparam logic [0:255][7:0] SBOX_TABLE = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage
`default_nettype wire

// File: rtl/ti_sbox_host_if.sv
`default_nettype none
// ============================================================================
// Module   : ti_sbox_host_if
// Purpose  : Pin bundle between the host initiator and the serial TI S-box port.
// Revision : 1.0 - initial release
// ============================================================================
interface ti_sbox_host_if;
    logic       dut_rst_n;
    logic       dut_load;
    logic [7:0] dut_data;
    logic       dut_ready;
    logic [7:0] dut_out;

    modport master (
        output dut_rst_n, dut_load, dut_data,
        input  dut_ready, dut_out
    );

    modport slave (
        input  dut_rst_n, dut_load, dut_data,
        output dut_ready, dut_out
    );
endinterface
`default_nettype wire

// File: rtl/ti_host_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : ti_host_lfsr
// Purpose  : 32-bit Galois LFSR randomness source for the TI S-box host.
// Revision : 1.0 - initial release
// ============================================================================
module ti_host_lfsr
    import ti_sbox_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        en,
    output logic [31:0]      value
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LFSR_SEED;
        end else if (en) begin
            r_state <= {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_POLY : 32'h0000_0000);
        end
    end

    assign value = r_state;

endmodule
`default_nettype wire

// File: rtl/ti_sbox_host.sv
`default_nettype none
// ============================================================================
// Module   : ti_sbox_host
// Purpose  : Masks a byte into TI shares, streams it to the serial S-box port,
//            captures and recombines the output shares.
// Options  : TI_HOST_LFSR_EN - internal LFSR replaces rand_in as randomness.
// Revision : 1.0 - initial release
// ============================================================================
module ti_sbox_host
    import ti_sbox_pkg::*;
#(
    parameter int RST_CYCLES    = 1,
    parameter int CAPTURE_DELAY = 2,
    parameter int TIMEOUT       = 15
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic [7:0]  data_in,
    input  wire logic [31:0] rand_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic             err,
    ti_sbox_host_if.master   sbox
);

    localparam logic [7:0] c_RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [7:0] c_LOAD_LAST = 8'(NUM_IN_BYTES);
    localparam logic [7:0] c_TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_SKIP_LAST = 8'(CAPTURE_DELAY - 2);
    localparam logic [7:0] c_CAP_LAST  = 8'(NUM_SHARES - 1);

    logic [31:0] w_rand;

`ifdef TI_HOST_LFSR_EN
    ti_host_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .value (w_rand)
    );
`else
    assign w_rand = rand_in;
`endif

    // Byte 0 goes out first: s1, s2, s3, R0, R1
    logic [NUM_IN_BYTES-1:0][7:0] w_bytes;
    assign w_bytes = {w_rand[31:24], w_rand[23:16],
                      data_in ^ w_rand[7:0] ^ w_rand[15:8],
                      w_rand[15:8], w_rand[7:0]};

    state_t                       r_state;
    logic [7:0]                   r_cnt;
    logic [NUM_IN_BYTES-1:0][7:0] r_bytes;
    logic [NUM_SHARES-1:0][7:0]   r_sh;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;
    logic [7:0]                   r_result;
    logic                         r_dut_rst_n;
    logic                         r_dut_load;
    logic [7:0]                   r_dut_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_bytes     <= '0;
            r_sh        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= 8'h00;
            r_dut_rst_n <= 1'b0;
            r_dut_load  <= 1'b0;
            r_dut_data  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dut_rst_n <= 1'b1;
                    if (start) begin
                        r_bytes     <= w_bytes;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_dut_rst_n <= 1'b0;
                        r_cnt       <= 8'd0;
                        r_state     <= ST_PREP;
                    end
                end
                // Port reset re-arms its sticky ready flag
                ST_PREP: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_dut_rst_n <= 1'b1;
                        r_dut_load  <= 1'b1;
                        r_dut_data  <= r_bytes[0];
                        r_bytes     <= {8'h00, r_bytes[NUM_IN_BYTES-1:1]};
                        r_cnt       <= 8'd1;
                        r_state     <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_LOAD: begin
                    if (r_cnt == c_LOAD_LAST) begin
                        r_dut_load <= 1'b0;
                        r_dut_data <= 8'h00;
                        r_cnt      <= 8'd0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_dut_data <= r_bytes[0];
                        r_bytes    <= {8'h00, r_bytes[NUM_IN_BYTES-1:1]};
                        r_cnt      <= r_cnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (sbox.dut_ready) begin
                        r_cnt <= 8'd0;
                        if (CAPTURE_DELAY > 1) begin
                            r_state <= ST_SKIP;
                        end else begin
                            r_state <= ST_CAP;
                        end
                    end else if (r_cnt == c_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_SKIP: begin
                    if (r_cnt == c_SKIP_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_CAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_CAP: begin
                    r_sh <= {sbox.dut_out, r_sh[NUM_SHARES-1:1]};
                    if (r_cnt == c_CAP_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                // Scrub mask-correlated state once the result is out
                ST_DONE: begin
                    r_result <= r_err ? 8'h00 : (r_sh[0] ^ r_sh[1] ^ r_sh[2]);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_bytes  <= '0;
                    r_sh     <= '0;
                    r_cnt    <= 8'd0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign result         = r_result;
    assign sbox.dut_rst_n = r_dut_rst_n;
    assign sbox.dut_load  = r_dut_load;
    assign sbox.dut_data  = r_dut_data;

endmodule
`default_nettype wire

// File: tb/tb_ti_sbox_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_ti_sbox_host
// Purpose  : Directed bench for ti_sbox_host against a cycle model of the TI S-box port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ti_sbox_host;
    import ti_sbox_pkg::*;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [31:0] rand_in = 32'h0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  result;

    ti_sbox_host_if sb ();

    ti_sbox_host dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .rand_in (rand_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err),
        .sbox    (sb)
    );

    always #5 clk = ~clk;

    // Port model: ready 2 edges after the 5th load, shares 2 edges after ready
    logic [0:255][7:0] golden = SBOX_TABLE;
    logic [7:0] m_b [5];
    int         m_n = 0;
    int         m_t = 0;
    logic       m_ready_en = 1'b1;
    logic [7:0] m_s;

    always_comb m_s = golden[m_b[0] ^ m_b[1] ^ m_b[2]];

    always @(posedge clk) begin
        if (!sb.dut_rst_n) begin
            m_n          <= 0;
            m_t          <= 0;
            sb.dut_ready <= 1'b0;
            sb.dut_out   <= 8'h00;
        end else begin
            if (sb.dut_load && m_n < 5) begin
                m_b[m_n] <= sb.dut_data;
                m_n      <= m_n + 1;
                if (m_n == 4) m_t <= 1;
            end
            if (m_t > 0 && m_t < 8) m_t <= m_t + 1;
            case (m_t)
                2: sb.dut_ready <= m_ready_en;
                4: sb.dut_out   <= m_s ^ m_b[3] ^ m_b[4];
                5: sb.dut_out   <= m_b[3];
                6: sb.dut_out   <= m_b[4];
                7: sb.dut_out   <= 8'h00;
                default: ;
            endcase
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] t_bytes [8];
    int         t_nload;
    int         t_lat;
    logic       t_rstlo;
    logic       t_busy0;
    logic       t_err0;
    logic       t_gotdone;

    task automatic run_txn(input logic [7:0] d, input logic [31:0] r, input int pulse_k);
        t_nload   = 0;
        t_lat     = -1;
        t_rstlo   = 1'b0;
        t_gotdone = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        rand_in = r;
        for (int k = 0; k < 60 && !t_gotdone; k++) begin
            @(negedge clk);
            start = (k == pulse_k);
            if (k == 0) begin
                t_busy0 = busy;
                t_err0  = err;
            end
            if (!sb.dut_rst_n) t_rstlo = 1'b1;
            if (sb.dut_load) begin
                if (t_nload < 8) t_bytes[t_nload] = sb.dut_data;
                t_nload++;
            end
            if (done) begin
                t_gotdone = 1'b1;
                t_lat     = k;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(t_gotdone), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    logic [7:0] exp_b [5];
    logic [7:0] d;
    logic [31:0] r;
    int         n_extra;
`ifdef TI_HOST_LFSR_EN
    logic [39:0] first_bytes;
`endif

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_err",       32'(err),          32'd0);
        check("rst_result",    32'(result),       32'h00);
        check("rst_dut_load",  32'(sb.dut_load),  32'd0);
        check("rst_dut_data",  32'(sb.dut_data),  32'h00);
        check("rst_dut_rst_n", 32'(sb.dut_rst_n), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_dut_rst_n", 32'(sb.dut_rst_n), 32'd1);

        // 1: plain shares
        run_txn(8'h53, 32'h0000_0000, -1);
        check("t1_busy_at_start", 32'(t_busy0), 32'd1);
        check("t1_nload",  32'(t_nload), 32'd5);
        check("t1_latency", 32'(t_lat),  32'd14);
        check("t1_result", 32'(result),  32'hED);
        check("t1_err",    32'(err),     32'd0);
        check("t1_busy_at_done", 32'(busy), 32'd0);
`ifndef TI_HOST_LFSR_EN
        exp_b = '{8'h00, 8'h00, 8'h53, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) check("t1_byte", 32'(t_bytes[i]), 32'(exp_b[i]));
`endif
        @(negedge clk);
        check("t1_done_one_cycle", 32'(done),   32'd0);
        check("t1_result_held",    32'(result), 32'hED);

        // 2: nonzero randomness
        run_txn(8'h00, 32'hDEAD_BEEF, -1);
        check("t2_result", 32'(result), 32'h63);
        check("t2_err",    32'(err),    32'd0);
`ifndef TI_HOST_LFSR_EN
        exp_b = '{8'hEF, 8'hBE, 8'h51, 8'hAD, 8'hDE};
        for (int i = 0; i < 5; i++) check("t2_byte", 32'(t_bytes[i]), 32'(exp_b[i]));
`endif

        // 3: back-to-back random transactions
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            r = $urandom;
            run_txn(d, r, -1);
            check("t3_result",   32'(result),  32'(golden[d]));
            check("t3_port_rst", 32'(t_rstlo), 32'd1);
            check("t3_nload",    32'(t_nload), 32'd5);
        end

        // 4: port never ready
        m_ready_en = 1'b0;
        run_txn(8'h53, 32'h1234_5678, -1);
        check("t4_latency", 32'(t_lat),  32'd22);
        check("t4_err",     32'(err),    32'd1);
        check("t4_result",  32'(result), 32'h00);
        m_ready_en = 1'b1;
        run_txn(8'h11, 32'h8765_4321, -1);
        check("t4_err_cleared_on_start", 32'(t_err0), 32'd0);
        check("t4_next_err",    32'(err),    32'd0);
        check("t4_next_result", 32'(result), 32'h82);

        // 5: reset during third LOAD cycle
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'h53;
        rand_in = 32'h0F0F_0F0F;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t5_in_load", 32'(sb.dut_load), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_busy",      32'(busy),         32'd0);
        check("t5_done",      32'(done),         32'd0);
        check("t5_err",       32'(err),          32'd0);
        check("t5_result",    32'(result),       32'h00);
        check("t5_dut_load",  32'(sb.dut_load),  32'd0);
        check("t5_dut_data",  32'(sb.dut_data),  32'h00);
        check("t5_dut_rst_n", 32'(sb.dut_rst_n), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(8'h53, 32'hCAFE_BABE, -1);
        check("t5_after_result",  32'(result), 32'hED);
        check("t5_after_latency", 32'(t_lat),  32'd14);

        // 6: start pulse during CAP is ignored
        run_txn(8'hA5, 32'h5A5A_1234, 11);
        check("t6_latency", 32'(t_lat),  32'd14);
        check("t6_result",  32'(result), 32'h06);
        n_extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) n_extra++;
        end
        check("t6_extra_done", 32'(n_extra), 32'd0);
        check("t6_busy_idle",  32'(busy),    32'd0);

`ifdef TI_HOST_LFSR_EN
        run_txn(8'h53, 32'h0, -1);
        first_bytes = {t_bytes[0], t_bytes[1], t_bytes[2], t_bytes[3], t_bytes[4]};
        check("lfsr_result_a", 32'(result), 32'hED);
        run_txn(8'h53, 32'h0, -1);
        check("lfsr_result_b", 32'(result), 32'hED);
        check("lfsr_bytes_differ",
              32'(first_bytes != {t_bytes[0], t_bytes[1], t_bytes[2], t_bytes[3], t_bytes[4]}), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
